load_down_counter: RTL and testbench



---
 rtl/load_down_counter.sv | 119 +++++++++++
 tb/tb_load_down_counter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_down_counter.sv
// load_down_counter
// -----------------------------------------------------------------------------
// Parametrised loadable down-counter with a programmable prescaler, a
// registered one-cycle terminal-count pulse and an optional auto-reload.
// Used for programmable delays and periodic ticks off the system clock.
//
// Parameters:
//   WIDTH  counter and load-value width (>= 2)
//   DIV_W  prescaler ratio width (>= 1)
//
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   synchronous, active-high reset
//   in     in   load value, sampled when latch = 1
//   latch  in   load 'in' into the counter (and reload register)
//   dec    in   decrement enable; gates the prescaler
//   div    in   prescale ratio: one decrement per div+1 enabled cycles
//   count  out  current counter value
//   zero   out  combinational decode of count == 0
//   tc     out  registered one-cycle terminal-count pulse
//
// Configuration macro:
//   LOAD_DOWN_COUNTER_AUTORELOAD_EN  when defined, a tick at count == 0
//   reloads the last latched value and pulses tc (periodic mode). When not
//   defined the counter is one-shot and sits at 0; the reload register is
//   not built.
// -----------------------------------------------------------------------------
module load_down_counter #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             latch,
    input  logic             dec,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc
);

    logic [DIV_W-1:0] pre;
    logic [WIDTH-1:0] countNext;
    logic [DIV_W-1:0] preNext;
    logic             tcNext;
    logic             preDone;

`ifdef LOAD_DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] rld;
`endif

    // A ">=" compare (not "==") so that lowering div below the current
    // prescaler phase produces a tick straight away instead of letting pre
    // run all the way around its range.
    assign preDone = (pre >= div);

    // Next-state decode. Priority is latch > dec > hold; reset is applied in
    // the register block. tc defaults low so it can only ever be a single
    // cycle pulse generated by a tick that lands on (or reloads from) zero.
    always_comb begin
        countNext = count;
        preNext   = pre;
        tcNext    = 1'b0;

        if (latch) begin
            countNext = in;
            preNext   = '0;
        end else if (dec) begin
            if (preDone) begin
                preNext = '0;
                if (count > WIDTH'(1)) begin
                    countNext = count - WIDTH'(1);
                end else if (count == WIDTH'(1)) begin
                    countNext = '0;
                    tcNext    = 1'b1;
                end else begin
`ifdef LOAD_DOWN_COUNTER_AUTORELOAD_EN
                    countNext = rld;
                    tcNext    = 1'b1;
`else
                    countNext = '0;
                    tcNext    = 1'b0;
`endif
                end
            end else begin
                preNext = pre + DIV_W'(1);
            end
        end
    end

    // State registers. Reset clears everything on the edge, which also
    // swallows any terminal-count pulse that would have been produced.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            pre   <= '0;
            tc    <= 1'b0;
        end else begin
            count <= countNext;
            pre   <= preNext;
            tc    <= tcNext;
        end
    end

`ifdef LOAD_DOWN_COUNTER_AUTORELOAD_EN
    // Reload register: remembers the last latched value for periodic mode.
    always_ff @(posedge clock) begin
        if (reset) begin
            rld <= '0;
        end else if (latch) begin
            rld <= in;
        end
    end
`endif

    assign zero = (count == '0);

endmodule

// File: tb/tb_load_down_counter.sv
// tb_load_down_counter
// -----------------------------------------------------------------------------
// Self-checking bench for load_down_counter. A behavioural model built from
// integer arithmetic tracks the expected count/tc every cycle; a compare
// process checks the DUT against it on each falling edge. Directed sequences
// also pin both DUT and model to hand-computed literal values, followed by a
// randomized run. Works with or without LOAD_DOWN_COUNTER_AUTORELOAD_EN.
// -----------------------------------------------------------------------------
module tb_load_down_counter;

    localparam int WIDTH = 4;
    localparam int DIV_W = 4;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] in;
    logic             latch;
    logic             dec;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc;

    int checks   = 0;
    int failures = 0;
    bit checking = 0;

    // Behavioural model state (plain integers).
    int mCount = 0;
    int mPre   = 0;
    int mRld   = 0;
    bit mTc    = 0;

    load_down_counter #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .latch (latch),
        .dec   (dec),
        .div   (div),
        .count (count),
        .zero  (zero),
        .tc    (tc)
    );

    // 100 MHz clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance the model by one clock edge given the inputs of that cycle.
    task automatic modelStep(input bit r, input bit l, input bit d, input int v, input int dv);
        if (r) begin
            mCount = 0; mPre = 0; mRld = 0; mTc = 0;
        end else if (l) begin
            mCount = v; mRld = v; mPre = 0; mTc = 0;
        end else if (d) begin
            if (mPre >= dv) begin
                mPre = 0;
                if (mCount >= 2) begin
                    mCount = mCount - 1; mTc = 0;
                end else if (mCount == 1) begin
                    mCount = 0; mTc = 1;
                end else begin
`ifdef LOAD_DOWN_COUNTER_AUTORELOAD_EN
                    mCount = mRld; mTc = 1;
`else
                    mTc = 0;
`endif
                end
            end else begin
                mPre = mPre + 1; mTc = 0;
            end
        end else begin
            mTc = 0;
        end
    endtask

    // Drive one cycle of inputs, step the model at the edge, return at negedge.
    task automatic applyStimulus(input bit r, input bit l, input bit d, input int v, input int dv);
        reset = r;
        latch = l;
        dec   = d;
        in    = WIDTH'(v);
        div   = DIV_W'(dv);
        @(posedge clock);
        modelStep(r, l, d, v, dv);
        @(negedge clock);
    endtask

    // Hand-computed expectation: pins both the DUT and the model.
    task automatic checkOutput(input int expCount, input bit expTc, input string name);
        checks++;
        if (count !== WIDTH'(expCount)) begin
            failures++;
            $display("[TB] FAIL %s count: got %0d, want %0d", name, count, expCount);
        end
        checks++;
        if (zero !== (expCount == 0)) begin
            failures++;
            $display("[TB] FAIL %s zero: got %0b, want %0b", name, zero, (expCount == 0));
        end
        checks++;
        if (tc !== expTc) begin
            failures++;
            $display("[TB] FAIL %s tc: got %0b, want %0b", name, tc, expTc);
        end
        checks++;
        if (mCount != expCount || mTc != expTc) begin
            failures++;
            $display("[TB] FAIL %s model: got count=%0d tc=%0b, want count=%0d tc=%0b",
                     name, mCount, mTc, expCount, expTc);
        end
    endtask

    // Cycle-by-cycle comparison of DUT outputs against the model.
    always @(negedge clock) begin
        if (checking) begin
            checks++;
            if (count !== WIDTH'(mCount)) begin
                failures++;
                $display("[TB] FAIL model_count @%0t: got %0d, want %0d", $time, count, mCount);
            end
            checks++;
            if (zero !== (mCount == 0)) begin
                failures++;
                $display("[TB] FAIL model_zero @%0t: got %0b, want %0b", $time, zero, (mCount == 0));
            end
            checks++;
            if (tc !== mTc) begin
                failures++;
                $display("[TB] FAIL model_tc @%0t: got %0b, want %0b", $time, tc, mTc);
            end
        end
    end

    initial begin
        int expSeq[7];
        bit expTcSeq[7];
        reset = 1'b0; latch = 1'b0; dec = 1'b0; in = '0; div = '0;

        // Reset held two cycles while latch/dec are also asserted.
        applyStimulus(1, 1, 1, 5, 0);
        checking = 1;
        applyStimulus(1, 1, 1, 5, 0);
        checkOutput(0, 0, "reset");
        applyStimulus(0, 0, 0, 5, 0);
        checkOutput(0, 0, "after_reset");

        // One-shot count from 5 with div = 0.
        applyStimulus(0, 1, 0, 5, 0);
        checkOutput(5, 0, "oneshot_load");
        for (int i = 4; i >= 0; i--) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkOutput(i, (i == 0), "oneshot_dec");
        end
`ifdef LOAD_DOWN_COUNTER_AUTORELOAD_EN
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput(5, 1, "oneshot_reload");
`else
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkOutput(0, 0, "oneshot_hold");
        end
`endif

        // Divide-by-two with a 3-cycle dec pause mid-count.
        applyStimulus(0, 1, 0, 5, 1);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput(5, 0, "div2_e1");
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput(4, 0, "div2_e2");
        applyStimulus(0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1);
            checkOutput(4, 0, "div2_pause");
        end
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput(3, 0, "div2_resume");
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, 1);
        checkOutput(0, 1, "div2_zero");

        // Latch wins over a running prescaler (div = 3, pre = 2).
        applyStimulus(0, 1, 0, 3, 3);
        applyStimulus(0, 0, 1, 0, 3);
        applyStimulus(0, 0, 1, 0, 3);
        applyStimulus(0, 1, 1, 9, 3);
        checkOutput(9, 0, "latch_priority");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 3);
        checkOutput(9, 0, "latch_pre_cleared");
        applyStimulus(0, 0, 1, 0, 3);
        checkOutput(8, 0, "latch_first_tick");

        // Reset on the edge where a zero-transition tick is pending.
        applyStimulus(0, 1, 0, 1, 0);
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput(0, 0, "reset_mid");
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput(0, 0, "reset_mid_after");

        // Periodic / terminal behaviour from 3 with div = 0.
`ifdef LOAD_DOWN_COUNTER_AUTORELOAD_EN
        expSeq   = '{2, 1, 0, 3, 2, 1, 0};
        expTcSeq = '{0, 0, 1, 1, 0, 0, 1};
`else
        expSeq   = '{2, 1, 0, 0, 0, 0, 0};
        expTcSeq = '{0, 0, 1, 0, 0, 0, 0};
`endif
        applyStimulus(0, 1, 0, 3, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkOutput(expSeq[i], expTcSeq[i], "reload_seq");
        end

        // Randomized run against the model.
        for (int i = 0; i < 800; i++) begin
            bit r, l, d;
            int v, dv;
            r  = ($urandom_range(0, 59) == 0);
            l  = ($urandom_range(0, 19) == 0);
            d  = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            dv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            applyStimulus(r, l, d, v, dv);
        end

        checking = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
